shift_ex_stage: RTL and testbench

Two-entry pipelined issue/capture stage that wraps the datapath's combinational 16-bit shifter in the execute stage. It accepts shift micro-ops from decode over a valid/ready handshake and selects the shift amount. It drives the shifter's operand and count ports from a registered operand stage, then captures the shifter result plus destination tag into a registered output stage feeding EX/MEM writeback. It gives one-per-cycle throughput, full backpressure, and a synchronous pipeline flush.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_pipe_reg.sv | 48 ++++
 rtl/shift_ex_stage.sv | 112 +++++++++++
 tb/tb_shift_ex_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared opcode encoding and width defaults for the execute-stage shift wrapper.
// No logic of its own; latency and backpressure belong to the modules using it.
// Only opcodes ROL..SRA are legal; is_legal_op screens the other three encodings.
package shift_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_TAG_W  = 3;

   typedef enum logic [2:0] {
      OP_ROL = 3'b000,
      OP_SLL = 3'b001,
      OP_ROR = 3'b010,
      OP_SRL = 3'b011,
      OP_SRA = 3'b100
   } shift_op_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op <= 3'(OP_SRA);
   endfunction

endpackage

// File: rtl/shift_pipe_reg.sv
// One-entry valid/data register slice used for both pipeline stages.
// Latency: one cycle from load_i to vld_o/dat_o.
// Backpressure: the caller decides load/clear; flush wins over both, load wins over clear.
module shift_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] dat_i,
   output logic         vld_o,
   output logic [W-1:0] dat_o
);

   logic         vld_d, vld_q;
   logic [W-1:0] dat_d, dat_q;

   // Next state: flush squashes, a load refills (even if draining), a clear empties.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush_i) begin
         vld_d = 1'b0;
      end else if (load_i) begin
         vld_d = 1'b1;
         dat_d = dat_i;
      end else if (clear_i) begin
         vld_d = 1'b0;
      end
   end

   // State register; data only moves on a load so it stays stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/shift_ex_stage.sv
// Two-entry issue/capture stage around the external combinational 16-bit shifter.
// Latency: op accepted at edge N appears on out_valid/out_data after edge N+1.
// Backpressure: in_ready drops only when both stages are full and out_ready is low, or on flush.
module shift_ex_stage #(
   parameter int DATA_W = shift_pkg::DEF_DATA_W,
   parameter int CNT_W  = shift_pkg::DEF_CNT_W,
   parameter int TAG_W  = shift_pkg::DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_use_imm,
   input  logic [CNT_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              flush,
   output logic [DATA_W-1:0] shf_in,
   output logic [CNT_W-1:0]  shf_cnt,
   output logic [2:0]        shf_op,
   input  logic [DATA_W-1:0] shf_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              illegal_op
);

   import shift_pkg::*;

   localparam int A_W = DATA_W + CNT_W + 3 + TAG_W;
   localparam int B_W = DATA_W + TAG_W;

   logic             accept, b_load, b_pop;
   logic             a_vld, b_vld, op_legal;
   logic [CNT_W-1:0] cnt_sel;
   logic [2:0]       op_sel;
   logic [A_W-1:0]   a_dat_in, a_dat;
   logic [B_W-1:0]   b_dat_in, b_dat;
   logic             illegal_d, illegal_q;
   logic             unused_rt_hi;

   // Only the low count bits of the register operand matter.
   assign unused_rt_hi = ^in_rt[DATA_W-1:CNT_W];

   assign op_legal = is_legal_op(in_op);

   // Pick the count at accept; an illegal op becomes a zero-count SLL so its data passes through.
   always_comb begin
      cnt_sel = in_use_imm ? in_imm : in_rt[CNT_W-1:0];
      op_sel  = in_op;
      if (!op_legal) begin
         op_sel  = 3'(OP_SLL);
         cnt_sel = '0;
      end
   end

   // B takes A whenever B is empty or being drained; A refills in the same edge.
   assign b_load   = a_vld && (!b_vld || out_ready);
   assign b_pop    = b_vld && out_ready;
   assign in_ready = !flush && (!a_vld || b_load);
   assign accept   = in_valid && in_ready;

   assign a_dat_in = {in_data, cnt_sel, op_sel, in_tag};
   assign b_dat_in = {shf_result, a_dat[TAG_W-1:0]};

   shift_pipe_reg #(.W(A_W)) u_stage_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (accept),
      .clear_i (b_load),
      .dat_i   (a_dat_in),
      .vld_o   (a_vld),
      .dat_o   (a_dat)
   );

   shift_pipe_reg #(.W(B_W)) u_stage_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (b_load),
      .clear_i (b_pop),
      .dat_i   (b_dat_in),
      .vld_o   (b_vld),
      .dat_o   (b_dat)
   );

   // The shifter always sees stage A, valid or not; B only samples it on b_load.
   assign {shf_in, shf_cnt, shf_op} = a_dat[A_W-1:TAG_W];
   assign {out_data, out_tag}       = b_dat;
   assign out_valid                 = b_vld;

   // Sticky illegal-op flag: set by accepting a bad opcode, cleared only by reset.
   always_comb begin
      illegal_d = illegal_q | (accept & ~op_legal);
   end

   // Flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: directed vector table, hand sequences, random traffic.
// An always-on monitor compares the DUT with an occupancy/queue reference model.
// The external shifter is modelled combinationally inside the bench.
module tb_shift_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_data;
   logic        in_use_imm;
   logic [3:0]  in_imm;
   logic [15:0] in_rt;
   logic [2:0]  in_tag;
   logic        flush;
   logic [15:0] shf_in;
   logic [3:0]  shf_cnt;
   logic [2:0]  shf_op;
   logic [15:0] shf_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_tag;
   logic        illegal_op;

   int checks = 0;
   int errors = 0;

   shift_ex_stage #(.DATA_W(16), .CNT_W(4), .TAG_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_data    (in_data),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .in_rt      (in_rt),
      .in_tag     (in_tag),
      .flush      (flush),
      .shf_in     (shf_in),
      .shf_cnt    (shf_cnt),
      .shf_op     (shf_op),
      .shf_result (shf_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External combinational shifter.
   always_comb begin
      case (shf_op)
         3'd0:    shf_result = (shf_in << shf_cnt) | (shf_in >> (5'd16 - 5'(shf_cnt)));
         3'd1:    shf_result = shf_in << shf_cnt;
         3'd2:    shf_result = (shf_in >> shf_cnt) | (shf_in << (5'd16 - 5'(shf_cnt)));
         3'd3:    shf_result = shf_in >> shf_cnt;
         3'd4:    shf_result = 16'($signed(shf_in) >>> shf_cnt);
         default: shf_result = shf_in;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference shift: repeated single-step arithmetic on an integer.
   function automatic logic [15:0] ref_shift(input logic [2:0] op, input logic [15:0] d, input int c);
      int v;
      v = int'(d);
      if (op > 3'd4) return d;
      for (int i = 0; i < c; i++) begin
         case (op)
            3'd0:    v = (v * 2) % 65536 + v / 32768;
            3'd1:    v = (v * 2) % 65536;
            3'd2:    v = v / 2 + (v % 2) * 32768;
            3'd3:    v = v / 2;
            default: v = v / 2 + ((v >= 32768) ? 32768 : 0);
         endcase
      end
      return 16'(v);
   endfunction

   // ---------------- reference model / monitor ----------------
   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  tag;
   } exp_t;

   exp_t q[$];
   bit   acc_last = 1'b0;
   bit   ill_m    = 1'b0;
   int   mon_n;
   exp_t mon_e;

   // Compare at the falling edge, then apply the handshakes the next rising edge will see.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         acc_last = 1'b0;
         ill_m    = 1'b0;
      end else begin
         mon_n = q.size();
         chk("mon_out_valid", 32'(out_valid), 32'((mon_n == 2) || (mon_n == 1 && !acc_last)));
         chk("mon_in_ready", 32'(in_ready), 32'(!flush && (mon_n < 2 || out_ready)));
         chk("mon_illegal", 32'(illegal_op), 32'(ill_m));
         if (out_valid && mon_n > 0) begin
            chk("mon_out_data", 32'(out_data), 32'(q[0].data));
            chk("mon_out_tag", 32'(out_tag), 32'(q[0].tag));
         end
         if (flush) begin
            q.delete();
            acc_last = 1'b0;
         end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               mon_e.data = ref_shift(in_op, in_data, in_use_imm ? int'(in_imm) : int'(in_rt[3:0]));
               mon_e.tag  = in_tag;
               q.push_back(mon_e);
               acc_last = 1'b1;
               if (in_op > 3'd4) ill_m = 1'b1;
            end else begin
               acc_last = 1'b0;
            end
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [2:0]  op;
      logic [15:0] data;
      logic        use_imm;
      logic [3:0]  imm;
      logic [15:0] rt;
      logic [2:0]  tag;
      logic [15:0] exp;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic drive_op(input logic [2:0] op, input logic [15:0] d, input logic ui,
                           input logic [3:0] imm, input logic [15:0] rt, input logic [2:0] tag);
      in_op      = op;
      in_data    = d;
      in_use_imm = ui;
      in_imm     = imm;
      in_rt      = rt;
      in_tag     = tag;
   endtask

   // Entered and left just after a rising edge with the stage empty.
   task automatic run_vec(input int i);
      drive_op(vecs[i].op, vecs[i].data, vecs[i].use_imm, vecs[i].imm, vecs[i].rt, vecs[i].tag);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{3'd4, 16'h8000, 1'b1, 4'd15, 16'h0000, 3'd5, 16'hFFFF};
      vecs[1] = '{3'd1, 16'h0001, 1'b0, 4'd9,  16'hFFF3, 3'd1, 16'h0008};
      vecs[2] = '{3'd2, 16'h0001, 1'b1, 4'd1,  16'h0000, 3'd2, 16'h8000};
      vecs[3] = '{3'd0, 16'h8001, 1'b1, 4'd4,  16'h0000, 3'd3, 16'h0018};
      vecs[4] = '{3'd3, 16'hF000, 1'b0, 4'd0,  16'h1234, 3'd4, 16'h0F00};
      vecs[5] = '{3'd4, 16'h7FFF, 1'b1, 4'd3,  16'h0000, 3'd6, 16'h0FFF};
      vecs[6] = '{3'd4, 16'h8421, 1'b1, 4'd0,  16'h0000, 3'd7, 16'h8421};
      vecs[7] = '{3'd2, 16'h1234, 1'b0, 4'd5,  16'h0010, 3'd0, 16'h1234};
      vecs[8] = '{3'd1, 16'h1234, 1'b1, 4'd7,  16'h0000, 3'd2, 16'h1A00};
      vecs[9] = '{3'd7, 16'h1234, 1'b1, 4'd7,  16'h0000, 3'd3, 16'h1234};

      rst_n = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive_op(3'd0, 16'h0, 1'b0, 4'd0, 16'h0, 3'd0);

      // Reset values while held in reset.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_shf_in", 32'(shf_in), 32'd0);
      chk("rst_shf_cnt", 32'(shf_cnt), 32'd0);
      chk("rst_shf_op", 32'(shf_op), 32'd0);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) run_vec(i);
      chk("illegal_set", 32'(illegal_op), 32'd1);

      // Back-to-back ops with out_ready high: no bubble, in_ready stays up.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive_op(3'd1, 16'h0001, 1'b0, 4'd0, 16'hFFF3, 3'd1);
      @(posedge clk); #1;
      drive_op(3'd2, 16'h0001, 1'b1, 4'd1, 16'h0000, 3'd2);
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid0", 32'(out_valid), 32'd1);
      chk("b2b_data0", 32'(out_data), 32'h0008);
      @(negedge clk);
      chk("b2b_valid1", 32'(out_valid), 32'd1);
      chk("b2b_data1", 32'(out_data), 32'h8000);
      chk("b2b_tag1", 32'(out_tag), 32'd2);
      @(posedge clk); #1;

      // Backpressure: out_ready low for 5 edges while streaming three ops.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(3'd3, 16'hF000, 1'b1, 4'd4, 16'h0000, 3'd3);
      @(posedge clk); #1;
      drive_op(3'd0, 16'h8001, 1'b1, 4'd4, 16'h0000, 3'd4);
      @(negedge clk);
      chk("bp_ready_one", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      drive_op(3'd1, 16'h0003, 1'b1, 4'd2, 16'h0000, 3'd6);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready_full", 32'(in_ready), 32'd0);
         chk("bp_hold_data", 32'(out_data), 32'h0F00);
         chk("bp_hold_tag", 32'(out_tag), 32'd3);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_drain", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_y", 32'(out_data), 32'h0018);
      @(negedge clk);
      chk("bp_out_z", 32'(out_data), 32'h000C);
      chk("bp_out_z_tag", 32'(out_tag), 32'd6);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_empty", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Flush with both stages full and a new op offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(3'd1, 16'h0001, 1'b1, 4'd1, 16'h0000, 3'd1);
      @(posedge clk); #1;
      drive_op(3'd1, 16'h0002, 1'b1, 4'd1, 16'h0000, 3'd2);
      @(posedge clk); #1;
      drive_op(3'd1, 16'h0003, 1'b1, 4'd1, 16'h0000, 3'd3);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      chk("fl_b_full", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("fl_not_taken", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      run_vec(0);
      chk("illegal_sticky", 32'(illegal_op), 32'd1);

      // Random traffic checked by the monitor.
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         drive_op(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom),
                  4'($urandom), 16'($urandom), 3'($urandom));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rand_drained", 32'(q.size()), 32'd0);
      chk("rand_idle", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Reset pulse with two ops in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op(3'd7, 16'hABCD, 1'b1, 4'd2, 16'h0000, 3'd5);
      @(posedge clk); #1;
      drive_op(3'd3, 16'h5555, 1'b1, 4'd1, 16'h0000, 3'd6);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_full", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_tag", 32'(out_tag), 32'd0);
      chk("mid_rst_shf_in", 32'(shf_in), 32'd0);
      chk("mid_rst_shf_cnt", 32'(shf_cnt), 32'd0);
      chk("mid_rst_shf_op", 32'(shf_op), 32'd0);
      chk("mid_rst_illegal", 32'(illegal_op), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      end
      chk("post_rst_illegal", 32'(illegal_op), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
